// File: rtl/abs_pipe.sv
// abs_pipe: registered sign-magnitude preprocessor for the divider (valid/ready on both sides).
// Optional two-entry skid buffer selected by defining ABS_PIPE_SKID_EN.
`default_nettype none

module abs_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_bits_a,
   input  logic [WIDTH-1:0] io_in_bits_b,
   input  logic             io_in_bits_signed,
   input  logic             io_in_bits_narrow,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_bits_aOut,
   output logic [WIDTH-1:0] io_out_bits_bOut,
   output logic             io_out_bits_aSign,
   output logic             io_out_bits_bSign,
   output logic             io_out_bits_divZero,
   output logic             io_out_bits_overflow
);

   localparam int              HALF    = WIDTH / 2;
   localparam int              RW      = 2 * WIDTH + 4;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] LO_MASK = {{HALF{1'b0}}, {HALF{1'b1}}};

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] min_neg;
   logic             a_sign;
   logic             b_sign;
   logic             div_zero;
   logic             overflow;
   logic [RW-1:0]    res;

   // Masking to the effective width makes the negate wrap modulo 2^N in both modes.
   always_comb begin
      mask     = io_in_bits_narrow ? LO_MASK : '1;
      a_eff    = io_in_bits_a & mask;
      b_eff    = io_in_bits_b & mask;
      a_sign   = io_in_bits_signed &
                 (io_in_bits_narrow ? io_in_bits_a[HALF-1] : io_in_bits_a[WIDTH-1]);
      b_sign   = io_in_bits_signed &
                 (io_in_bits_narrow ? io_in_bits_b[HALF-1] : io_in_bits_b[WIDTH-1]);
      a_mag    = a_sign ? ((~a_eff + ONE) & mask) : a_eff;
      b_mag    = b_sign ? ((~b_eff + ONE) & mask) : b_eff;
      min_neg  = io_in_bits_narrow ? (ONE << (HALF - 1)) : (ONE << (WIDTH - 1));
      div_zero = (b_eff == '0);
      overflow = io_in_bits_signed && (a_eff == min_neg) && (b_eff == mask);
      res      = {a_mag, b_mag, a_sign, b_sign, div_zero, overflow};
   end

   logic          in_fire;
   logic          out_fire;
   logic [RW-1:0] main_q;
   logic [RW-1:0] main_d;
   logic          valid_q;
   logic          valid_d;

   assign in_fire  = io_in_valid && io_in_ready;
   assign out_fire = valid_q && io_out_ready;

`ifdef ABS_PIPE_SKID_EN
   logic [RW-1:0] skid_q;
   logic [RW-1:0] skid_d;
   logic          skid_valid_q;
   logic          skid_valid_d;

   assign io_in_ready = !skid_valid_q;

   // Main slot refills from skid first so ordering stays FIFO.
   always_comb begin
      main_d       = main_q;
      valid_d      = valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!valid_q || out_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_d  = res;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = res;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_q       <= '0;
         valid_q      <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         valid_q      <= valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign io_in_ready = !valid_q || io_out_ready;

   always_comb begin
      main_d  = main_q;
      valid_d = valid_q;
      if (in_fire) begin
         main_d  = res;
         valid_d = 1'b1;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         main_q  <= main_d;
         valid_q <= valid_d;
      end
   end
`endif

   assign io_out_valid = valid_q;
   assign {io_out_bits_aOut, io_out_bits_bOut, io_out_bits_aSign,
           io_out_bits_bSign, io_out_bits_divZero, io_out_bits_overflow} = main_q;

endmodule

`default_nettype wire

// File: tb/tb_abs_pipe.sv
// Testbench for abs_pipe: directed test-plan vectors plus randomized traffic against an arithmetic model.
`default_nettype none

module tb_abs_pipe;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         as;
      logic         bs;
      logic         dz;
      logic         ov;
   } res_t;

`ifdef ABS_PIPE_SKID_EN
   localparam int EXP_FILL = 2;
`else
   localparam int EXP_FILL = 1;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_signed = 1'b0;
   logic         in_narrow = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic         out_as;
   logic         out_bs;
   logic         out_dz;
   logic         out_ov;
   res_t         out_bits;

   int checks   = 0;
   int failures = 0;
   res_t q[$];
   logic last_in_fire;

   always #5 clock = ~clock;

   assign out_bits = '{a: out_a, b: out_b, as: out_as, bs: out_bs, dz: out_dz, ov: out_ov};

   abs_pipe #(.WIDTH(W)) dut (
      .clock               (clock),
      .reset               (reset),
      .io_in_valid         (in_valid),
      .io_in_ready         (in_ready),
      .io_in_bits_a        (in_a),
      .io_in_bits_b        (in_b),
      .io_in_bits_signed   (in_signed),
      .io_in_bits_narrow   (in_narrow),
      .io_out_valid        (out_valid),
      .io_out_ready        (out_ready),
      .io_out_bits_aOut    (out_a),
      .io_out_bits_bOut    (out_b),
      .io_out_bits_aSign   (out_as),
      .io_out_bits_bSign   (out_bs),
      .io_out_bits_divZero (out_dz),
      .io_out_bits_overflow(out_ov)
   );

   // Reference: magnitudes from integer arithmetic modulo 2^N.
   function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic sg, logic nr);
      res_t r;
      longint unsigned m, ae, be, half;
      m    = 64'd1 << (nr ? W / 2 : W);
      half = m / 2;
      ae   = longint'(a) % m;
      be   = longint'(b) % m;
      r.as = sg && (ae >= half);
      r.bs = sg && (be >= half);
      r.a  = W'(r.as ? (m - ae) % m : ae);
      r.b  = W'(r.bs ? (m - be) % m : be);
      r.dz = (be == 0);
      r.ov = sg && (ae == half) && (be == m - 1);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [$bits(res_t)-1:0] obs,
                      input logic [$bits(res_t)-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against scoreboard at negedge, then update it after the edge.
   task automatic cycle();
      logic fi, fo;
      res_t nxt;
      @(negedge clock);
      chk("out_valid", $bits(res_t)'(out_valid), $bits(res_t)'(q.size() != 0));
      if (q.size() != 0) chk("out_bits", out_bits, q[0]);
      fi  = in_valid && in_ready;
      fo  = out_valid && out_ready;
      nxt = model(in_a, in_b, in_signed, in_narrow);
      @(posedge clock);
      #1;
      if (fo && q.size() != 0) void'(q.pop_front());
      if (fi) q.push_back(nxt);
      last_in_fire = fi;
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return {$urandom_range(0, 65535)} << 16 | 32'h0000_8000;
         4: return {$urandom_range(0, 65535)} << 16 | 32'h0000_FFFF;
         5: return {$urandom_range(0, 65535)} << 16;
         default: return $urandom;
      endcase
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input logic nr, input res_t exp, input string tag);
      in_a = a; in_b = b; in_signed = sg; in_narrow = nr;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk({tag, "_accepted"}, $bits(res_t)'(last_in_fire), $bits(res_t)'(1'b1));
      chk({tag, "_valid"}, $bits(res_t)'(out_valid), $bits(res_t)'(1'b1));
      chk(tag, out_bits, exp);
      cycle();
   endtask

   initial begin
      int acc;
      logic [W-1:0] ca, cb;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_valid", $bits(res_t)'(out_valid), '0);
      chk("reset_bits", out_bits, '0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("ready_after_reset", $bits(res_t)'(in_ready), $bits(res_t)'(1'b1));

      send(32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 1'b0,
           '{a: 32'd7, b: 32'd3, as: 1'b1, bs: 1'b0, dz: 1'b0, ov: 1'b0}, "neg7_div3");
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,
           '{a: 32'h8000_0000, b: 32'd1, as: 1'b1, bs: 1'b1, dz: 1'b0, ov: 1'b1}, "ovf_signed");
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
           '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, as: 1'b0, bs: 1'b0, dz: 1'b0, ov: 1'b0}, "ovf_unsigned");
      send(32'hABCD_8000, 32'h1234_0000, 1'b1, 1'b1,
           '{a: 32'h0000_8000, b: 32'd0, as: 1'b1, bs: 1'b0, dz: 1'b1, ov: 1'b0}, "narrow_dz");
      send(32'hFFFF_8000, 32'h0000_FFFF, 1'b1, 1'b1,
           '{a: 32'h0000_8000, b: 32'd1, as: 1'b1, bs: 1'b1, dz: 1'b0, ov: 1'b1}, "narrow_ovf");

      // Eight back-to-back requests with out_ready toggling every cycle.
      acc = 0;
      for (int k = 0; k < 60 && acc < 8; k++) begin
         in_a = rand_op(); in_b = rand_op();
         in_signed = 1'($urandom); in_narrow = 1'($urandom);
         in_valid  = 1'b1;
         out_ready = k[0];
         cycle();
         if (last_in_fire) acc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && q.size() != 0; k++) cycle();
      chk("toggle_accepted", $bits(res_t)'(acc), $bits(res_t)'(8));
      chk("toggle_drained", $bits(res_t)'(q.size()), '0);

      // Fill with a stalled consumer until ready drops.
      acc = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_a = rand_op(); in_b = rand_op();
         in_signed = 1'b1; in_narrow = 1'($urandom);
         in_valid  = 1'b1;
         cycle();
         if (last_in_fire) acc++;
         if (!in_ready) break;
      end
      in_valid = 1'b0;
      chk("fill_count", $bits(res_t)'(acc), $bits(res_t)'(EXP_FILL));
      repeat (2) cycle();
      out_ready = 1'b1;
      for (int k = 0; k < 6 && q.size() != 0; k++) cycle();
      chk("fill_drained", $bits(res_t)'(q.size()), '0);

      // Reset while an entry is held.
      out_ready = 1'b0;
      ca = 32'h8000_0000; cb = 32'hFFFF_FFFF;
      in_a = ca; in_b = cb; in_signed = 1'b1; in_narrow = 1'b0;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("held_valid", $bits(res_t)'(out_valid), $bits(res_t)'(1'b1));
      #2 reset = 1'b0;
      #1;
      chk("async_reset_valid", $bits(res_t)'(out_valid), '0);
      chk("async_reset_bits", out_bits, '0);
      q.delete();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("ready_after_rst2", $bits(res_t)'(in_ready), $bits(res_t)'(1'b1));
      out_ready = 1'b1;
      repeat (3) cycle();

      // Randomized traffic with random backpressure.
      for (int k = 0; k < 400; k++) begin
         in_a = rand_op(); in_b = rand_op();
         in_signed = 1'($urandom); in_narrow = 1'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6 && q.size() != 0; k++) cycle();
      chk("final_drained", $bits(res_t)'(q.size()), '0);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
